// File: rtl/comp_ora.sv
// comp_ora: session-based multi-channel output response analyser.
// Compares CUT responses (A) against golden responses (B) on each valid cycle
// of a fixed-length session, accumulating sticky per-channel fail flags, a
// saturating mismatch count and the first failing pattern index, then reports
// pass/fail through a start/done handshake.
// Optional feature: define COMP_ORA_BITMAP_EN to add the per-bit fail_bits map.
module comp_ora #(
  parameter int unsigned BITS     = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PATTERNS = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDX_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     valid,
  input  logic [CHANNELS*BITS-1:0] A,
  input  logic [CHANNELS*BITS-1:0] B,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CHANNELS-1:0]      fail_ch,
  output logic [CNT_W-1:0]         mismatch_cnt,
`ifdef COMP_ORA_BITMAP_EN
  output logic [CHANNELS*BITS-1:0] fail_bits,
`endif
  output logic [IDX_W-1:0]         first_fail_idx
);

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(PATTERNS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [CHANNELS-1:0]   fail_ch_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      first_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CHANNELS-1:0]   m;
  logic                  pm;
  logic                  clear;
  logic                  upd;
  logic                  last;

  // Per-channel and whole-pattern mismatch of the current A/B pair
  always_comb begin
    m = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      m[c] = |(A[c*BITS +: BITS] ^ B[c*BITS +: BITS]);
    end
    pm = |m;
  end

  assign last = (idx_q == LastIdx);

  // Next-state and datapath strobes; abort overrides start and valid
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    upd     = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            clear   = 1'b1;
          end
        end
        StRun: begin
          if (valid) begin
            upd = 1'b1;
            if (last) state_d = StDone;
          end
        end
        StDone: begin
          if (start) begin
            state_d = StRun;
            clear   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Session accumulators: cleared on session start, updated on accepted patterns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_ch_q <= '0;
      cnt_q     <= '0;
      first_q   <= '0;
      idx_q     <= '0;
    end else if (clear) begin
      fail_ch_q <= '0;
      cnt_q     <= '0;
      first_q   <= '0;
      idx_q     <= '0;
    end else if (upd) begin
      fail_ch_q <= fail_ch_q | m;
      if (pm && (cnt_q != CntMax)) cnt_q <= cnt_q + 1'b1;
      // Counter saturates and never returns to zero, so zero means "no fail yet"
      if (pm && (cnt_q == '0)) first_q <= idx_q;
      // Index holds on the last pattern so it never exceeds PATTERNS-1
      if (!last) idx_q <= idx_q + 1'b1;
    end
  end

`ifdef COMP_ORA_BITMAP_EN
  logic [CHANNELS*BITS-1:0] fail_bits_q;

  // Sticky per-bit mismatch map over the session
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fail_bits_q <= '0;
    else if (clear) fail_bits_q <= '0;
    else if (upd)   fail_bits_q <= fail_bits_q | (A ^ B);
  end

  assign fail_bits = fail_bits_q;
`endif

  assign busy           = (state_q == StRun);
  assign done           = (state_q == StDone);
  // fail_ch already includes the final update by the time DONE is reached
  assign pass           = done && (fail_ch_q == '0);
  assign fail_ch        = fail_ch_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = first_q;

endmodule

// File: doc/comp_ora.md
Name: comp_ora

Overview:
Multi-channel, session-based output response analyser for the LBIST ORA #2 path. It compares CUT responses (A) against golden responses (B) on every valid cycle across a fixed-length test session. It accumulates per-channel fail flags, a saturating mismatch count and the index of the first failing pattern. At session end it reports pass/fail to the BIST controller through a start/done handshake.

Parameters:
BITS, 2, bits per channel per pattern
CHANNELS, 4, number of independent compared channels
PATTERNS, 16, valid compares per session (>=1)
CNT_W, 8, width of mismatch counter (saturating)
IDX_W, 8, width of pattern index; PATTERNS must be <= 2**IDX_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin session (honoured in IDLE or DONE only)
abort  in  1  terminate session, return to IDLE
valid  in  1  A/B carry a pattern this cycle
A  in  CHANNELS*BITS  CUT response; channel c = bits [c*BITS +: BITS]
B  in  CHANNELS*BITS  golden response, same packing
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid when done: 1 = no mismatch in session
fail_ch  out  CHANNELS  sticky per-channel mismatch flags
mismatch_cnt  out  CNT_W  patterns with >=1 mismatching channel, saturating
first_fail_idx  out  IDX_W  pattern index of first mismatch (0 if none)

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy=0, done=0, pass=0, fail_ch=0, mismatch_cnt=0, first_fail_idx=0, internal pattern index=0.
- Channel mismatch: m[c] = |(A_c ^ B_c) (1 when unequal, same polarity as comp). Pattern mismatch pm = |m.
- FSM: IDLE -start-> RUN; RUN -last valid-> DONE; DONE -start-> RUN; any state -abort-> IDLE. abort has priority over start and valid.
- Entering RUN (start edge): same clock clears fail_ch, mismatch_cnt, first_fail_idx, index, pass. The start cycle does not sample A/B.
- RUN, valid=1: registered update, visible next cycle: fail_ch |= m; if pm, mismatch_cnt += 1 saturating at 2**CNT_W-1; if pm and mismatch_cnt==0, first_fail_idx = index; index += 1.
- valid=0 in RUN: no update, index holds; stalls are unbounded.
- Last pattern: the valid cycle with index==PATTERNS-1 updates as above and moves to DONE next cycle. There, done=1, busy=0, pass = (fail_ch==0 including final update).
- DONE: outputs held until start (new session) or abort. valid ignored in IDLE and DONE.
- start in RUN ignored. abort in RUN: IDLE next cycle, done=0, pass=0; fail_ch/mismatch_cnt/first_fail_idx retain partial values.
- Index wrap: none; it never exceeds PATTERNS-1 within a session.
- Latency: compare-to-flag 1 cycle; last valid to done 1 cycle.

Optional Feature:
Macro COMP_ORA_BITMAP_EN.
- Defined: adds output fail_bits (CHANNELS*BITS), sticky OR of A^B per bit over the session. Cleared on reset and session start, held in DONE and after abort.
- Undefined: no fail_bits port or logic; all other behaviour identical.

Test Plan:
- BITS=2, CHANNELS=4, PATTERNS=16; start, 16 valid cycles A==B -> done=1 one cycle after 16th valid, pass=1, fail_ch=0, mismatch_cnt=0.
- Same, pattern 5 A=8'h00 B=8'h04 (channel 1), pattern 9 A=8'h00 B=8'hC0 (channel 3) -> pass=0, fail_ch=4'b1010, mismatch_cnt=2, first_fail_idx=5.
- CNT_W=2, all 16 patterns mismatch -> mismatch_cnt saturates at 3, first_fail_idx=0, fail_ch per stimulus.
- Valid toggled 1/0 every cycle -> done only after 16th valid (~32 cycles); start pulsed mid-RUN -> no effect on counts.
- abort after 7 valids with 1 mismatch -> IDLE next cycle, done=0, mismatch_cnt=1 held; new start clears to 0; rst_n low mid-RUN -> all outputs 0 immediately.
- With COMP_ORA_BITMAP_EN: mismatches 8'h01 then 8'h80 -> fail_bits=8'h81 in DONE; cleared on next start.
